// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART command sequencer slice.
package uart_alu_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_SEND,
        S_WAIT_TX
    } state_e;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_NOR = 6'h27;

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte timeout: counts tick_16x while enabled, flags the TIMEOUT_TICKS-th tick.
module byte_timeout_timer #(
    parameter int unsigned TIMEOUT_TICKS = 16384
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic tick_16x,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry fires combinationally on the tick that would make the count reach the limit.
    assign expired = enable & tick_16x & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable || expired) begin
            cnt_d = '0;
        end else if (tick_16x) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_alu_sequencer.sv
// Collects A, B, opcode from UART RX, registers the ALU result and hands it to UART TX.
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int unsigned OPCODE_WIDTH  = 6,
    parameter int unsigned TIMEOUT_TICKS = 16384,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick_16x,
    input  logic                    rx_done_tick,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_error_frame,
    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    output logic [OPCODE_WIDTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    output logic                    tx_start,
    output logic [DATA_WIDTH-1:0]   tx_data,
    input  logic                    tx_busy,
    input  logic                    tx_done_tick,
    output logic                    busy,
    output logic                    timeout_pulse,
    output logic [CNT_WIDTH-1:0]    frame_err_cnt,
    output logic [CNT_WIDTH-1:0]    overrun_cnt
);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [OPCODE_WIDTH-1:0] alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [CNT_WIDTH-1:0]    fe_cnt_q, fe_cnt_d;
    logic [CNT_WIDTH-1:0]    ov_cnt_q, ov_cnt_d;
    logic                    timer_en, timer_expired;

    assign timer_en = (state_q == S_WAIT_B) || (state_q == S_WAIT_OP);

    byte_timeout_timer #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (rx_done_tick),
        .enable   (timer_en),
        .tick_16x (tick_16x),
        .expired  (timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        tx_data_d     = tx_data_q;
        fe_cnt_d      = fe_cnt_q;
        ov_cnt_d      = ov_cnt_q;
        tx_start      = 1'b0;
        timeout_pulse = 1'b0;

        case (state_q)
            S_WAIT_A, S_WAIT_B, S_WAIT_OP: begin
                // A received byte takes priority over a coincident timeout.
                if (rx_done_tick) begin
                    if (rx_error_frame) begin
                        if (fe_cnt_q != '1) fe_cnt_d = fe_cnt_q + 1'b1;
                        state_d = S_WAIT_A;
                    end else if (state_q == S_WAIT_A) begin
                        alu_a_d = rx_data;
                        state_d = S_WAIT_B;
                    end else if (state_q == S_WAIT_B) begin
                        alu_b_d = rx_data;
                        state_d = S_WAIT_OP;
                    end else begin
                        alu_op_d = rx_data[OPCODE_WIDTH-1:0];
                        state_d  = S_EXEC;
                    end
                end else if (timer_expired) begin
                    timeout_pulse = 1'b1;
                    state_d       = S_WAIT_A;
                end
            end
            S_EXEC: begin
                tx_data_d = alu_result;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                if (tx_done_tick) state_d = S_WAIT_A;
            end
            default: state_d = S_WAIT_A;
        endcase

        if (rx_done_tick && !timer_en && (state_q != S_WAIT_A)) begin
            if (ov_cnt_q != '1) ov_cnt_d = ov_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_WAIT_A;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            tx_data_q <= '0;
            fe_cnt_q  <= '0;
            ov_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            tx_data_q <= tx_data_d;
            fe_cnt_q  <= fe_cnt_d;
            ov_cnt_q  <= ov_cnt_d;
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_op        = alu_op_q;
    assign tx_data       = tx_data_q;
    assign frame_err_cnt = fe_cnt_q;
    assign overrun_cnt   = ov_cnt_q;
    assign busy          = (state_q != S_WAIT_A);

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed bench for uart_alu_sequencer with a behavioural ALU and TX handshake.
module tb_uart_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_16x = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_error_frame = 1'b0;
    logic [7:0] alu_a, alu_b, alu_result, tx_data;
    logic [5:0] alu_op;
    logic       tx_start, tx_busy = 1'b0, tx_done_tick = 1'b0;
    logic       busy, timeout_pulse;
    logic [7:0] frame_err_cnt, overrun_cnt;

    int total = 0;
    int bad = 0;
    int txs_cnt = 0;
    int tp_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [5:0] op);
        case (op)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h03: return $unsigned($signed(a) >>> b[2:0]);
            6'h02: return a >> b[2:0];
            6'h27: return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op);

    uart_alu_sequencer #(
        .DATA_WIDTH    (8),
        .OPCODE_WIDTH  (6),
        .TIMEOUT_TICKS (32),
        .CNT_WIDTH     (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tick_16x       (tick_16x),
        .rx_done_tick   (rx_done_tick),
        .rx_data        (rx_data),
        .rx_error_frame (rx_error_frame),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_op         (alu_op),
        .alu_result     (alu_result),
        .tx_start       (tx_start),
        .tx_data        (tx_data),
        .tx_busy        (tx_busy),
        .tx_done_tick   (tx_done_tick),
        .busy           (busy),
        .timeout_pulse  (timeout_pulse),
        .frame_err_cnt  (frame_err_cnt),
        .overrun_cnt    (overrun_cnt)
    );

    // Inputs change 1 time unit after posedge, so negedge sampling of pulses is race-free.
    always @(negedge clk) begin
        if (tx_start === 1'b1) txs_cnt++;
        if (timeout_pulse === 1'b1) tp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic err);
        step();
        rx_data        = d;
        rx_error_frame = err;
        rx_done_tick   = 1'b1;
        step();
        rx_done_tick   = 1'b0;
        rx_error_frame = 1'b0;
    endtask

    task automatic pulse_tick();
        step();
        tick_16x = 1'b1;
        step();
        tick_16x = 1'b0;
    endtask

    task automatic finish_tx();
        step();
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
    endtask

    // Full command with idle TX: checks result, single tx_start and return to idle.
    task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp);
        int s0;
        s0 = txs_cnt;
        send_byte(a, 1'b0);
        send_byte(b, 1'b0);
        send_byte(op, 1'b0);
        chk({tag, "_exec_busy"}, busy, 1);
        step();
        chk({tag, "_tx_data"}, tx_data, exp);
        chk({tag, "_tx_start"}, tx_start, 1);
        step();
        step();
        finish_tx();
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_starts"}, txs_cnt - s0, 1);
    endtask

    initial begin
        int s0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", alu_a, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_fe", frame_err_cnt, 0);
        chk("rst_ov", overrun_cnt, 0);
        step();
        reset = 1'b0;

        // 1: ADD 5 + 3
        run_cmd("t1", 8'h05, 8'h03, 8'h20, 8'h08);
        chk("t1_a", alu_a, 8'h05);
        chk("t1_b", alu_b, 8'h03);
        chk("t1_op", alu_op, 6'h20);

        // 2: frame error on B, then SUB 7 - 2
        send_byte(8'h10, 1'b0);
        send_byte(8'hAA, 1'b1);
        chk("t2_fe", frame_err_cnt, 1);
        chk("t2_busy", busy, 0);
        chk("t2_a_kept", alu_a, 8'h10);
        chk("t2_b_kept", alu_b, 8'h03);
        run_cmd("t2", 8'h07, 8'h02, 8'h22, 8'h05);

        // 3: timeout after A, then OR 0F | F0
        send_byte(8'h11, 1'b0);
        repeat (31) pulse_tick();
        chk("t3_pre_tp", tp_cnt, 0);
        chk("t3_pre_busy", busy, 1);
        pulse_tick();
        chk("t3_tp", tp_cnt, 1);
        chk("t3_busy", busy, 0);
        run_cmd("t3", 8'h0F, 8'hF0, 8'h25, 8'hFF);
        chk("t3_tp_once", tp_cnt, 1);

        // 4: TX busy on SEND entry, then overrun in WAIT_TX
        tx_busy = 1'b1;
        s0 = txs_cnt;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h20, 1'b0);
        repeat (20) step();
        chk("t4_held_start", txs_cnt - s0, 0);
        chk("t4_held_busy", busy, 1);
        chk("t4_tx_data", tx_data, 8'h03);
        tx_busy = 1'b0;
        step();
        step();
        chk("t4_one_start", txs_cnt - s0, 1);
        send_byte(8'h77, 1'b0);
        chk("t4_overrun", overrun_cnt, 1);
        chk("t4_a_kept", alu_a, 8'h01);
        chk("t4_wait_tx", busy, 1);
        finish_tx();
        chk("t4_idle", busy, 0);
        chk("t4_starts_total", txs_cnt - s0, 1);

        // 5: reset in WAIT_TX and in WAIT_OP
        send_byte(8'h09, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h26, 1'b0);
        step();
        step();
        chk("t5_in_wait_tx", busy, 1);
        reset = 1'b1;
        #1;
        chk("t5a_busy", busy, 0);
        chk("t5a_a", alu_a, 0);
        chk("t5a_op", alu_op, 0);
        chk("t5a_tx_data", tx_data, 0);
        chk("t5a_fe", frame_err_cnt, 0);
        chk("t5a_ov", overrun_cnt, 0);
        s0 = txs_cnt;
        step();
        reset = 1'b0;
        step();
        step();
        chk("t5a_no_start", txs_cnt - s0, 0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        reset = 1'b1;
        #1;
        chk("t5b_busy", busy, 0);
        chk("t5b_b", alu_b, 0);
        step();
        reset = 1'b0;
        step();
        run_cmd("t5", 8'h06, 8'h03, 8'h24, 8'h02);

        // 6: frame error counter saturation
        repeat (255) send_byte(8'h00, 1'b1);
        chk("t6_255", frame_err_cnt, 8'hFF);
        send_byte(8'h00, 1'b1);
        chk("t6_sat", frame_err_cnt, 8'hFF);
        chk("t6_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
